// File: rtl/shiftreg_pkg.sv
// Shared definitions for the display/button shift-register chains.
//
// Contents:
//   SHIFTREG_DEFAULT_DIV - default shift-clock half-period in clk cycles.
//                          The reader and the transmitter both use it, so the
//                          two chains run at the same rate.
//   shiftreg_tx_state_t  - transmitter FSM states.
//   buttonsT             - board button map, shared by both chain directions.
//   cnt_width()          - counter width helper that never returns 0 bits.
package shiftreg_pkg;

  localparam int SHIFTREG_DEFAULT_DIV = 25;

  typedef enum logic [1:0] {IDLE, SETUP, CLK_HI, LATCH} shiftreg_tx_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic btn_a;
    logic btn_b;
    logic start;
    logic select;
  } buttonsT;

  // $clog2(1) is 0, which would give zero-width counters for the
  // degenerate WIDTH=1 / CLK_DIV=1 configurations.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shiftreg_tx_if.sv
// Parallel-word handshake between a producer and shiftreg_tx.
//
// Signals:
//   data_in   - word to transmit (WIDTH bits)
//   valid_in  - data_in valid
//   ready_out - transmitter can accept a word
//   busy      - transfer in progress (= ~ready_out)
//
// Modports: master (producer side), slave (transmitter side).
interface shiftreg_tx_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             busy;

  modport master (output data_in, output valid_in, input ready_out, input busy);
  modport slave  (input data_in, input valid_in, output ready_out, output busy);

endinterface

// File: rtl/shiftreg_tick.sv
// Phase timer for the shift-register FSM: counts clk cycles 0..CLK_DIV-1
// and flags the last cycle of each phase.
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clear - synchronous clear, holds the count at 0
//   tick  - high during the last cycle (count == CLK_DIV-1) of a phase
module shiftreg_tick
  import shiftreg_pkg::*;
#(
  parameter int CLK_DIV = SHIFTREG_DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Wrapping on tick lines the count up with the FSM's state changes, so
  // every phase starts from 0 without the FSM having to clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/shiftreg_tx.sv
// Serial-out transmitter for the display-board 74HC595-style chain.
// Accepts a parallel word over a valid/ready handshake, shifts it MSB-first
// on sr_data (sampled on sr_clk rising edge), then pulses sr_latch.
// Each SETUP / CLK_HI / LATCH phase lasts CLK_DIV clk cycles, so the block
// is busy for (2*WIDTH+1)*CLK_DIV cycles per word.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   bus      - shiftreg_tx_if.slave (data_in, valid_in, ready_out, busy)
//   sr_clk   - shift clock to the chain (registered)
//   sr_data  - serial data, MSB first (registered)
//   sr_latch - storage-register latch pulse, active high (registered)
//
// Optional feature, macro SHIFTREG_TX_AUTO_REFRESH_EN: after REFRESH idle
// cycles without a handshake, the last accepted word (0 before any accept)
// is resent. An external valid_in in the expiry cycle wins.
module shiftreg_tx
  import shiftreg_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = SHIFTREG_DEFAULT_DIV,
  parameter int REFRESH = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  shiftreg_tx_if.slave bus,
  output logic         sr_clk,
  output logic         sr_data,
  output logic         sr_latch
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);

  if (WIDTH < 1 || CLK_DIV < 1 || REFRESH < 1) begin : g_param_check
    $error("shiftreg_tx: WIDTH, CLK_DIV and REFRESH must all be >= 1");
  end

  shiftreg_tx_state_t state, state_next;
  logic [WIDTH-1:0]   shreg, shreg_next;
  logic [BW-1:0]      bit_cnt, bit_cnt_next;
  logic               phase_done;
  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   load_word;
  logic               sr_clk_d, sr_data_d, sr_latch_d;

  assign bus.ready_out = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.valid_in && (state == IDLE);

`ifdef SHIFTREG_TX_AUTO_REFRESH_EN
  localparam int RW = cnt_width(REFRESH);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH - 1);

  logic [RW-1:0]    refresh_cnt;
  logic [WIDTH-1:0] last_q;
  logic             refresh_due;

  assign refresh_due = (state == IDLE) && !bus.valid_in && (refresh_cnt == REFRESH_LAST);

  // Idle-time counter and resend copy. The counter cannot run past
  // REFRESH_LAST: in that cycle either an accept or a refresh resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      last_q      <= '0;
    end else begin
      if (accept) begin
        last_q <= bus.data_in;
      end
      if (accept || refresh_due) begin
        refresh_cnt <= '0;
      end else if (state == IDLE) begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  assign load      = accept || refresh_due;
  assign load_word = accept ? bus.data_in : last_q;
`else
  assign load      = accept;
  assign load_word = bus.data_in;
`endif

  // The divider is held at 0 while idle, so the first SETUP phase after a
  // load is a full CLK_DIV cycles long.
  shiftreg_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .tick  (phase_done)
  );

  // State register plus datapath and registered pin outputs. Async reset
  // forces all pins low at once, so an interrupted frame is never latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      sr_clk   <= 1'b0;
      sr_data  <= 1'b0;
      sr_latch <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      sr_clk   <= sr_clk_d;
      sr_data  <= sr_data_d;
      sr_latch <= sr_latch_d;
    end
  end

  // Next-state logic. The shift happens when leaving CLK_HI so the next
  // bit is already on sr_data for the whole following SETUP phase.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        if (load) begin
          state_next   = SETUP;
          shreg_next   = load_word;
          bit_cnt_next = TOP_BIT;
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_next = CLK_HI;
        end
      end
      CLK_HI: begin
        if (phase_done) begin
          if (bit_cnt == '0) begin
            state_next = LATCH;
          end else begin
            shreg_next   = shreg << 1;
            bit_cnt_next = bit_cnt - 1'b1;
            state_next   = SETUP;
          end
        end
      end
      LATCH: begin
        if (phase_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so that, once registered,
  // they change on the same edge as the state itself.
  always_comb begin
    sr_clk_d   = (state_next == CLK_HI);
    sr_latch_d = (state_next == LATCH);
    sr_data_d  = ((state_next == SETUP) || (state_next == CLK_HI)) ? shreg_next[WIDTH-1] : 1'b0;
  end

endmodule

// File: doc/shiftreg_tx.md
Name: shiftreg_tx

Overview:
- Serial-out transmitter for the display-board shift-register chain; the write-direction counterpart of the button shift-register reader.
- Takes a parallel word over a valid/ready handshake and shifts it MSB-first on sr_data with a divided shift clock, then pulses a storage latch (74HC595-style SIPO chain).
- Instantiated in toplevel to drive external indicator LEDs, e.g. from core pc/acc.

Parameters:
WIDTH, 16, bits per transfer (>=1)
CLK_DIV, 25, clk cycles per shift-clock half-period (>=1)
REFRESH, 1000000, clk cycles between automatic resends (only with SHIFTREG_TX_AUTO_REFRESH_EN)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  word to transmit
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a word
busy  output  1  transfer in progress (= ~ready_out)
sr_clk  output  1  shift clock to chain; data sampled on its rising edge
sr_data  output  1  serial data, MSB first
sr_latch  output  1  storage-register latch pulse, active high

Behaviour:
- Reset (async assert, sync release): state IDLE; sr_clk=0, sr_data=0, sr_latch=0, ready_out=1, busy=0; shift register and counters 0.
- sr_clk, sr_data and sr_latch are registered. ready_out is decoded from the state: 1 only in IDLE.
- Accept: a word is accepted on the rising edge where valid_in && ready_out. On that edge:
  - shreg <= data_in, bit_cnt <= WIDTH-1, div_cnt <= 0, state <= SETUP.
- valid_in while busy is ignored. Changes to data_in after acceptance have no effect.
- State SETUP: sr_clk=0, sr_data=shreg[WIDTH-1]; hold CLK_DIV cycles, then go to CLK_HI.
- State CLK_HI: sr_clk=1, sr_data held; hold CLK_DIV cycles. Then:
  - if bit_cnt==0, go to LATCH;
  - else shreg <= shreg<<1, bit_cnt--, go to SETUP.
- State LATCH: sr_clk=0, sr_latch=1, sr_data=0; hold CLK_DIV cycles, then sr_latch=0 and go to IDLE.
- Latency: ready_out is low for exactly (2*WIDTH+1)*CLK_DIV cycles after the accept edge.
- A new word may be accepted on the first IDLE cycle (back-to-back). There is at most one IDLE cycle between transfers under continuous valid_in.
- div_cnt counts 0..CLK_DIV-1 and wraps to 0 on each state change. bit_cnt is $clog2(WIDTH) bits wide and never wraps below 0.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. No latch pulse is emitted, so the external chain keeps its previously latched value.
- The stored last word (last_q) is updated only on accept.

Optional Feature:
- Macro SHIFTREG_TX_AUTO_REFRESH_EN.
- Defined:
  - A refresh counter increments every cycle in IDLE and resets on any accept.
  - When it reaches REFRESH-1 with no valid_in in IDLE, the block self-loads last_q and performs a normal transfer; ready_out drops exactly as for an external accept.
  - valid_in in the same cycle as refresh expiry takes priority: the external word is sent and the counter resets.
  - Before the first accept, refresh sends 0.
- Undefined: no refresh counter or last_q register; transfers occur only on handshake.

Decomposition:
- Package shiftreg_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, CLK_HI, LATCH} shiftreg_tx_state_t;
  - localparam SHIFTREG_DEFAULT_DIV=25, shared with the reader so both chains run at the same rate.
  - The buttonsT struct moves here so both directions share board definitions.
- One sub-module is natural: shiftreg_tick (CLK_DIV divider with sync clear, emitting a 1-cycle tick). The FSM uses it for phase timing.

Test Plan:
- WIDTH=16, CLK_DIV=2, send 16'hA5C3:
  - 16 sr_clk rising edges; sampled bits 1010_0101_1100_0011;
  - then sr_latch high 2 cycles;
  - ready_out low exactly 66 cycles.
- valid_in held high with 16'h0001 then 16'h8000 → second accept on the first IDLE cycle; second frame's first sampled bit=1, last=0.
- valid_in pulsed and data_in toggled during a transfer → ignored; frame matches the originally accepted word; no extra accept.
- rst_n low at bit 7 of 16'hFFFF → sr_clk, sr_data and sr_latch go 0 immediately; no latch pulse; ready_out=1 after release.
- WIDTH=1, CLK_DIV=1 edge case: send 1'b1 → 1 clock edge, latch 1 cycle, ready_out low 3 cycles.
- With SHIFTREG_TX_AUTO_REFRESH_EN, REFRESH=50, after sending 16'h1234 → identical 16'h1234 frame restarts 50 cycles after IDLE entry; a coincident external valid_in with 16'h00FF wins.
